spi_wb_master: RTL

- SPI-slave to Wishbone-master bridge sitting between the SPI pads (spi_sck/spi_csn/spi_sdi/spi_sdo) and the internal Wishbone bus that feeds peripherals such as the charlie7x5 driver.
- Decodes framed SPI transactions into Wishbone B4 classic single read/write cycles with address auto-increment.
- All logic runs in the system clock domain. The SPI inputs are oversampled.

---
 rtl/spi_wb_pkg.sv | 13 +
 rtl/spi_slave_phy.sv | 93 +++++++++
 rtl/spi_wb_master.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/spi_wb_pkg.sv
// Shared constants and FSM encoding for the SPI-slave to Wishbone-master bridge.
package spi_wb_pkg;
  localparam int         CMD_WRITE_BIT = 7;
  localparam logic [7:0] DUMMY_BYTE    = 8'h00;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WDATA,
    RDUMMY,
    RDATA
  } state_e;
endpackage

// File: rtl/spi_slave_phy.sv
// SPI mode-0 slave front end: input synchronizers, edge detect, rx/tx shifters, bit counter.
module spi_slave_phy (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_sck,
  input  logic       spi_csn,
  input  logic       spi_sdi,
  output logic       spi_sdo,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_start,
  output logic       frame_end,
  input  logic [7:0] tx_byte,
  input  logic       tx_load
);
  // [0],[1] are the synchronizer stages, [2] holds the previous synced value
  logic [2:0] sck_q, sck_d, csn_q, csn_d;
  logic [1:0] sdi_q, sdi_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_sr_q, rx_sr_d, rx_byte_q, rx_byte_d, tx_sr_q, tx_sr_d;
  logic       rx_valid_q, rx_valid_d, fstart_q, fstart_d, fend_q, fend_d;
  logic       sck_rise, sck_fall, in_frame;

  always_comb begin
    sck_d      = {sck_q[1:0], spi_sck};
    csn_d      = {csn_q[1:0], spi_csn};
    sdi_d      = {sdi_q[0], spi_sdi};
    sck_rise   = sck_q[1] & ~sck_q[2];
    sck_fall   = ~sck_q[1] & sck_q[2];
    // Uses the previous csn so an edge coinciding with csn rising still counts.
    in_frame   = ~csn_q[2];
    fstart_d   = ~csn_q[1] & csn_q[2];
    fend_d     = csn_q[1] & ~csn_q[2];
    bit_cnt_d  = bit_cnt_q;
    rx_sr_d    = rx_sr_q;
    rx_byte_d  = rx_byte_q;
    rx_valid_d = 1'b0;
    tx_sr_d    = tx_sr_q;

    if (fstart_d) begin
      bit_cnt_d = '0;
      rx_sr_d   = '0;
    end else if (in_frame && sck_rise) begin
      rx_sr_d   = {rx_sr_q[6:0], sdi_q[1]};
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        rx_valid_d = 1'b1;
        rx_byte_d  = {rx_sr_q[6:0], sdi_q[1]};
      end
    end

    // The fall right after a byte boundary (count back at 0) must not shift,
    // otherwise the freshly loaded MSB would be lost before the master samples it.
    if (fstart_d)
      tx_sr_d = '0;
    else if (tx_load)
      tx_sr_d = tx_byte;
    else if (in_frame && sck_fall && bit_cnt_q != 3'd0)
      tx_sr_d = {tx_sr_q[6:0], 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_q      <= 3'b000;
      csn_q      <= 3'b111;
      sdi_q      <= 2'b00;
      bit_cnt_q  <= '0;
      rx_sr_q    <= '0;
      rx_byte_q  <= '0;
      tx_sr_q    <= '0;
      rx_valid_q <= 1'b0;
      fstart_q   <= 1'b0;
      fend_q     <= 1'b0;
    end else begin
      sck_q      <= sck_d;
      csn_q      <= csn_d;
      sdi_q      <= sdi_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_sr_q    <= rx_sr_d;
      rx_byte_q  <= rx_byte_d;
      tx_sr_q    <= tx_sr_d;
      rx_valid_q <= rx_valid_d;
      fstart_q   <= fstart_d;
      fend_q     <= fend_d;
    end
  end

  assign rx_byte     = rx_byte_q;
  assign rx_valid    = rx_valid_q;
  assign frame_start = fstart_q;
  assign frame_end   = fend_q;
  assign spi_sdo     = tx_sr_q[7] & ~csn_q[1];
endmodule

// File: rtl/spi_wb_master.sv
// SPI-slave to Wishbone-master bridge: command decode FSM, address counter and
// single-cycle Wishbone B4 classic read/write issue.
module spi_wb_master #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_sck,
  input  logic              spi_csn,
  input  logic              spi_sdi,
  output logic              spi_sdo,
  output logic              wb_cyc,
  output logic              wb_stb,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_adr,
  output logic [DATA_W-1:0] wb_dat_o,
  input  logic [DATA_W-1:0] wb_dat_i,
  input  logic              wb_ack,
  output logic              overrun
);
  import spi_wb_pkg::*;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, adr_q, adr_d, addr_cur;
  logic [DATA_W-1:0] dat_q, dat_d, rbuf_q, rbuf_d, rd_now;
  logic              cyc_q, cyc_d, we_q, we_d, ovr_q, ovr_d;
  logic              ack_now, pending;
  logic [7:0]        rx_byte, tx_byte;
  logic              rx_valid, frame_start, frame_end, tx_load;

  spi_slave_phy u_phy (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi_sck    (spi_sck),
    .spi_csn    (spi_csn),
    .spi_sdi    (spi_sdi),
    .spi_sdo    (spi_sdo),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .frame_start(frame_start),
    .frame_end  (frame_end),
    .tx_byte    (tx_byte),
    .tx_load    (tx_load)
  );

  always_comb begin
    // An ack sampled this clk completes the cycle, so a byte boundary in the
    // same clk is not an overrun and sees the post-increment address / read data.
    ack_now  = cyc_q & wb_ack;
    pending  = cyc_q & ~wb_ack;
    addr_cur = ack_now ? addr_q + ADDR_W'(1) : addr_q;
    rd_now   = (ack_now & ~we_q) ? wb_dat_i : rbuf_q;

    state_d  = state_q;
    addr_d   = addr_cur;
    cyc_d    = pending;
    we_d     = we_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    rbuf_d   = rd_now;
    ovr_d    = 1'b0;
    tx_load  = 1'b0;
    tx_byte  = DUMMY_BYTE;

    if (rx_valid) begin
      case (state_q)
        CMD: begin
          addr_d = rx_byte[ADDR_W-1:0];
          if (rx_byte[CMD_WRITE_BIT]) begin
            state_d = WDATA;
          end else begin
            state_d = RDUMMY;
            tx_load = 1'b1;
            if (pending) begin
              ovr_d = 1'b1;
            end else begin
              cyc_d = 1'b1;
              we_d  = 1'b0;
              adr_d = rx_byte[ADDR_W-1:0];
            end
          end
        end
        WDATA: begin
          if (pending) begin
            ovr_d = 1'b1;
          end else begin
            cyc_d = 1'b1;
            we_d  = 1'b1;
            adr_d = addr_cur;
            dat_d = rx_byte;
          end
        end
        RDUMMY, RDATA: begin
          state_d = RDATA;
          tx_load = 1'b1;
          if (pending) begin
            ovr_d = 1'b1;
          end else begin
            tx_byte = rd_now;
            cyc_d   = 1'b1;
            we_d    = 1'b0;
            adr_d   = addr_cur;
          end
        end
        default: ;
      endcase
    end

    if (frame_end)
      state_d = IDLE;
    else if (frame_start)
      state_d = CMD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      rbuf_q  <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      rbuf_q  <= rbuf_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      ovr_q   <= ovr_d;
    end
  end

  assign wb_cyc   = cyc_q;
  assign wb_stb   = cyc_q;
  assign wb_we    = we_q;
  assign wb_adr   = adr_q;
  assign wb_dat_o = dat_q;
  assign overrun  = ovr_q;
endmodule
